hazard_ctrl: RTL and testbench

- Hazard and forwarding controller for the 5-stage RISC-V pipeline. It tracks in-flight destination registers for the EX, MEM and WB stages in an internal shadow pipeline.
- It drives the ID-stage operand mux select (if_forward[3:0]) and stalls the front end on load-use hazards.
- It squashes the ID instruction on redirect and counts stall cycles for CPI analysis.
- It sits beside the ID stage and is the only source of if_forward.

---
 rtl/hazard_ctrl.sv | 154 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, operand forwarding select and stall-cycle
// statistics for the 5-stage pipeline, driven by a shadow EX/MEM/WB slot chain.
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid_inst,
    input  logic [4:0]       id_ra_idx,
    input  logic [4:0]       id_rb_idx,
    input  logic             id_uses_ra,
    input  logic             id_uses_rb,
    input  logic             id_reg_wr,
    input  logic             id_rd_mem,
    input  logic [4:0]       id_dest_reg_idx,
    input  logic             flush,
    input  logic             pipe_hold,
    input  logic             stat_clr,
    output logic [3:0]       if_forward,
    output logic             stall,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef struct packed {
        logic       v;
        logic       wr;
        logic       ld;
        logic [4:0] dst;
    } slot_t;

    slot_t            r_ex;
    slot_t            r_mem;
    // Load data is always available at WB, so the WB slot keeps no load flag.
    logic             r_wb_v;
    logic             r_wb_wr;
    logic [4:0]       r_wb_dst;
    logic [CNT_W-1:0] r_cnt;

    slot_t            w_ex_nxt;
    logic             w_ra_ex;
    logic             w_ra_mem;
    logic             w_ra_wb;
    logic             w_rb_ex;
    logic             w_rb_mem;
    logic             w_rb_wb;
    logic             w_raw_stall;
    logic             w_stall;
    logic [1:0]       w_sel_a;
    logic [1:0]       w_sel_b;

    function automatic logic f_hit(
        input logic       v,
        input logic       wr,
        input logic [4:0] dst,
        input logic [4:0] idx
    );
        return v & wr & (dst != 5'd0) & (dst == idx);
    endfunction

    function automatic logic [1:0] f_sel(
        input logic use_op,
        input logic hit_ex,
        input logic ld_ex,
        input logic hit_mem,
        input logic ld_mem,
        input logic hit_wb
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (use_op) begin
            if (hit_ex && !ld_ex)
                sel = 2'b01;
            else if (hit_mem && !ld_mem)
                sel = 2'b10;
            else if (hit_wb)
                sel = 2'b11;
        end
        return sel;
    endfunction

    // Per-operand slot matches against the in-flight destinations.
    always_comb begin
        w_ra_ex  = f_hit(r_ex.v, r_ex.wr, r_ex.dst, id_ra_idx);
        w_ra_mem = f_hit(r_mem.v, r_mem.wr, r_mem.dst, id_ra_idx);
        w_ra_wb  = f_hit(r_wb_v, r_wb_wr, r_wb_dst, id_ra_idx);
        w_rb_ex  = f_hit(r_ex.v, r_ex.wr, r_ex.dst, id_rb_idx);
        w_rb_mem = f_hit(r_mem.v, r_mem.wr, r_mem.dst, id_rb_idx);
        w_rb_wb  = f_hit(r_wb_v, r_wb_wr, r_wb_dst, id_rb_idx);
    end

    // Load-use detection, stall, and forward selects.
    always_comb begin
        w_raw_stall = (id_uses_ra &
                       ((w_ra_ex & r_ex.ld) | (w_ra_mem & r_mem.ld))) |
                      (id_uses_rb &
                       ((w_rb_ex & r_ex.ld) | (w_rb_mem & r_mem.ld)));
        w_stall = id_valid_inst & w_raw_stall & ~flush;
        w_sel_a = f_sel(id_uses_ra, w_ra_ex, r_ex.ld,
                        w_ra_mem, r_mem.ld, w_ra_wb);
        w_sel_b = f_sel(id_uses_rb, w_rb_ex, r_ex.ld,
                        w_rb_mem, r_mem.ld, w_rb_wb);
    end

    // Drive outputs; a dead or stalled ID instruction reads the regfile.
    always_comb begin
        stall        = w_stall;
        stall_cycles = r_cnt;
        if (w_stall || flush || !id_valid_inst)
            if_forward = 4'b0000;
        else
            if_forward = {w_sel_b, w_sel_a};
    end

    // Next EX slot: a bubble unless a live instruction leaves ID.
    always_comb begin
        w_ex_nxt = '0;
        if (id_valid_inst && !flush && !w_stall) begin
            w_ex_nxt.v   = 1'b1;
            w_ex_nxt.wr  = id_reg_wr;
            w_ex_nxt.ld  = id_rd_mem;
            w_ex_nxt.dst = id_dest_reg_idx;
        end
    end

    // Shadow pipeline advance, frozen while the pipeline is held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ex     <= '0;
            r_mem    <= '0;
            r_wb_v   <= 1'b0;
            r_wb_wr  <= 1'b0;
            r_wb_dst <= 5'd0;
        end else if (!pipe_hold) begin
            r_wb_v   <= r_mem.v;
            r_wb_wr  <= r_mem.wr;
            r_wb_dst <= r_mem.dst;
            r_mem    <= r_ex;
            r_ex     <= w_ex_nxt;
        end
    end

    // Saturating stall-cycle counter; clear beats increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (!pipe_hold) begin
            if (stat_clr)
                r_cnt <= '0;
            else if (w_stall && (r_cnt != {CNT_W{1'b1}}))
                r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed pipeline scenarios plus random traffic checked
// against an in-flight instruction history model.
module tb_hazard_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          id_valid_inst = 1'b0;
    logic [4:0]    id_ra_idx = 5'd0;
    logic [4:0]    id_rb_idx = 5'd0;
    logic          id_uses_ra = 1'b0;
    logic          id_uses_rb = 1'b0;
    logic          id_reg_wr = 1'b0;
    logic          id_rd_mem = 1'b0;
    logic [4:0]    id_dest_reg_idx = 5'd0;
    logic          flush = 1'b0;
    logic          pipe_hold = 1'b0;
    logic          stat_clr = 1'b0;
    logic [3:0]    if_forward;
    logic          stall;
    logic [CW-1:0] stall_cycles;

    hazard_ctrl #(.CNT_W(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid_inst   (id_valid_inst),
        .id_ra_idx       (id_ra_idx),
        .id_rb_idx       (id_rb_idx),
        .id_uses_ra      (id_uses_ra),
        .id_uses_rb      (id_uses_rb),
        .id_reg_wr       (id_reg_wr),
        .id_rd_mem       (id_rd_mem),
        .id_dest_reg_idx (id_dest_reg_idx),
        .flush           (flush),
        .pipe_hold       (pipe_hold),
        .stat_clr        (stat_clr),
        .if_forward      (if_forward),
        .stall           (stall),
        .stall_cycles    (stall_cycles)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // History of the last three instructions to leave ID (0 = youngest).
    logic       m_v[3];
    logic       m_wr[3];
    logic       m_ld[3];
    logic [4:0] m_dst[3];
    int         m_cnt;
    logic       e_stall;
    logic [3:0] e_fwd;
    int         c0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mreset();
        for (int k = 0; k < 3; k++) begin
            m_v[k] = 1'b0; m_wr[k] = 1'b0;
            m_ld[k] = 1'b0; m_dst[k] = 5'd0;
        end
        m_cnt = 0;
    endtask

    function automatic void mexp(output logic [3:0] f, output logic s);
        logic       haz;
        logic [1:0] sel[2];
        logic [4:0] idx;
        logic       use_op;
        haz = 1'b0;
        for (int op = 0; op < 2; op++) begin
            idx    = (op == 0) ? id_ra_idx : id_rb_idx;
            use_op = (op == 0) ? id_uses_ra : id_uses_rb;
            sel[op] = 2'd0;
            if (use_op && idx != 5'd0) begin
                for (int k = 2; k >= 0; k--) begin
                    if (m_v[k] && m_wr[k] && m_dst[k] == idx) begin
                        sel[op] = 2'(k + 1);
                        if (k < 2 && m_ld[k]) haz = 1'b1;
                    end
                end
            end
        end
        s = id_valid_inst & haz & ~flush;
        f = (s || flush || !id_valid_inst) ? 4'b0 : {sel[1], sel[0]};
    endfunction

    task automatic drive(input logic v, input logic wr, input logic ld,
                         input logic [4:0] rd, input logic [4:0] ra,
                         input logic ua, input logic [4:0] rb,
                         input logic ub, input logic fl,
                         input logic hd, input logic cl);
        id_valid_inst = v; id_reg_wr = wr; id_rd_mem = ld;
        id_dest_reg_idx = rd; id_ra_idx = ra; id_uses_ra = ua;
        id_rb_idx = rb; id_uses_rb = ub;
        flush = fl; pipe_hold = hd; stat_clr = cl;
        #1;
        mexp(e_fwd, e_stall);
        chk("fwd", 32'(if_forward), 32'(e_fwd));
        chk("stall", 32'(stall), 32'(e_stall));
        chk("cnt", 32'(stall_cycles), 32'(m_cnt));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst && !pipe_hold) begin
            for (int k = 2; k > 0; k--) begin
                m_v[k] = m_v[k-1]; m_wr[k] = m_wr[k-1];
                m_ld[k] = m_ld[k-1]; m_dst[k] = m_dst[k-1];
            end
            if (flush || e_stall || !id_valid_inst) begin
                m_v[0] = 1'b0; m_wr[0] = 1'b0;
                m_ld[0] = 1'b0; m_dst[0] = 5'd0;
            end else begin
                m_v[0] = 1'b1; m_wr[0] = id_reg_wr;
                m_ld[0] = id_rd_mem; m_dst[0] = id_dest_reg_idx;
            end
            if (stat_clr) m_cnt = 0;
            else if (e_stall && m_cnt < (1 << CW) - 1) m_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic alu(input logic [4:0] rd, input logic [4:0] ra,
                       input logic ua, input logic [4:0] rb,
                       input logic ub);
        drive(1'b1, 1'b1, 1'b0, rd, ra, ua, rb, ub, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic lw(input logic [4:0] rd);
        drive(1'b1, 1'b1, 1'b1, rd, 5'd0, 1'b0, 5'd0, 1'b0,
              1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0,
                  1'b0, 1'b0, 1'b0);
            tick();
        end
    endtask

    initial begin
        mreset();
        #2;
        chk("rst_fwd", 32'(if_forward), 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_cnt", 32'(stall_cycles), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // ALU back-to-back, one, two and three gaps.
        for (int gap = 0; gap < 4; gap++) begin
            idle(3);
            alu(5'd5, 5'd0, 1'b0, 5'd0, 1'b0);
            tick();
            idle(gap);
            alu(5'd6, 5'd5, 1'b1, 5'd5, 1'b1);
            case (gap)
                0: chk("alu_gap0", 32'(if_forward), 32'b0101);
                1: chk("alu_gap1", 32'(if_forward), 32'b1010);
                2: chk("alu_gap2", 32'(if_forward), 32'b1111);
                default: chk("alu_gap3", 32'(if_forward), 32'b0000);
            endcase
            chk("alu_nostall", 32'(stall), 32'h0);
            tick();
        end

        // Load-use: two stalls then MEM/WB select.
        idle(3);
        lw(5'd7); tick();
        for (int i = 0; i < 2; i++) begin
            alu(5'd8, 5'd7, 1'b1, 5'd0, 1'b0);
            chk("lu_stall", 32'(stall), 32'h1);
            tick();
        end
        alu(5'd8, 5'd7, 1'b1, 5'd0, 1'b0);
        chk("lu_fwd", 32'(if_forward), 32'b0011);
        chk("lu_cnt", 32'(stall_cycles), 32'd2);
        tick();

        // Priority: youngest writer wins; x0 never forwards.
        idle(3);
        alu(5'd3, 5'd0, 1'b0, 5'd0, 1'b0); tick();
        alu(5'd3, 5'd0, 1'b0, 5'd0, 1'b0); tick();
        alu(5'd4, 5'd3, 1'b1, 5'd3, 1'b1);
        chk("prio", 32'(if_forward), 32'b0101);
        tick();
        idle(3);
        alu(5'd0, 5'd0, 1'b0, 5'd0, 1'b0); tick();
        alu(5'd9, 5'd0, 1'b1, 5'd0, 1'b1);
        chk("x0_fwd", 32'(if_forward), 32'b0000);
        chk("x0_stall", 32'(stall), 32'h0);
        tick();

        // Flush kills the dependent instruction and leaves a bubble.
        idle(3);
        c0 = m_cnt;
        lw(5'd7); tick();
        drive(1'b1, 1'b1, 1'b0, 5'd8, 5'd7, 1'b1, 5'd0, 1'b0,
              1'b1, 1'b0, 1'b0);
        chk("fl_stall", 32'(stall), 32'h0);
        chk("fl_fwd", 32'(if_forward), 32'h0);
        tick();
        alu(5'd10, 5'd8, 1'b1, 5'd0, 1'b0);
        chk("fl_bubble", 32'(if_forward), 32'b0000);
        chk("fl_cnt", 32'(stall_cycles), 32'(c0));
        tick();

        // Hold for three cycles in the middle of a load-use stall.
        idle(3);
        c0 = m_cnt;
        lw(5'd7); tick();
        repeat (3) begin
            drive(1'b1, 1'b1, 1'b0, 5'd8, 5'd7, 1'b1, 5'd0, 1'b0,
                  1'b0, 1'b1, 1'b0);
            chk("hold_stall", 32'(stall), 32'h1);
            chk("hold_cnt", 32'(stall_cycles), 32'(c0));
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            alu(5'd8, 5'd7, 1'b1, 5'd0, 1'b0);
            chk("hold_rel", 32'(stall), 32'h1);
            tick();
        end
        alu(5'd8, 5'd7, 1'b1, 5'd0, 1'b0);
        chk("hold_fwd", 32'(if_forward), 32'b0011);
        chk("hold_total", 32'(stall_cycles), 32'(c0 + 2));
        tick();

        // Asynchronous reset mid-stall.
        idle(3);
        lw(5'd7); tick();
        alu(5'd8, 5'd7, 1'b1, 5'd0, 1'b0);
        chk("ar_pre", 32'(stall), 32'h1);
        rst = 1'b0;
        #1;
        mreset();
        chk("ar_stall", 32'(stall), 32'h0);
        chk("ar_cnt", 32'(stall_cycles), 32'h0);
        chk("ar_fwd", 32'(if_forward), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Saturation at all-ones.
        repeat (9) begin
            lw(5'd7); tick();
            repeat (3) begin
                alu(5'd8, 5'd7, 1'b1, 5'd0, 1'b0);
                tick();
            end
        end
        idle(1);
        chk("sat", 32'(stall_cycles), 32'd15);

        // Clear wins over a simultaneous stall.
        lw(5'd7); tick();
        drive(1'b1, 1'b1, 1'b0, 5'd8, 5'd7, 1'b1, 5'd0, 1'b0,
              1'b0, 1'b0, 1'b1);
        chk("clr_stall", 32'(stall), 32'h1);
        tick();
        alu(5'd8, 5'd7, 1'b1, 5'd0, 1'b0);
        chk("clr_cnt", 32'(stall_cycles), 32'h0);
        tick();

        // Random traffic on a small register window.
        repeat (3000) begin
            logic hd;
            hd = ($urandom_range(0, 6) == 0);
            drive($urandom_range(0, 9) != 0,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) == 0,
                  5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)),
                  $urandom_range(0, 4) != 0,
                  5'($urandom_range(0, 3)),
                  $urandom_range(0, 1) != 0,
                  $urandom_range(0, 9) == 0,
                  hd,
                  !hd && ($urandom_range(0, 40) == 0));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
